mem_port_arbiter: RTL and testbench

- Shares the data port of the dual-port instruction/data RAM between two requesters: M0 (CPU load/store unit) and M1 (debug/DMA loader).
- Arbitrates every cycle and drives the RAM data port combinationally.
- Returns a one-cycle-latency response (read data or write ack) to the requester that issued the access.
- Supports bus locking for atomic sequences and, in fixed-priority mode, starvation protection for M1.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle linking the two requesters (M0 load/store unit, M1 debug/DMA loader)
// to the data-port arbiter, and the arbiter to the RAM data port.
interface mem_port_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic        m0_lock;
  logic [29:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_be;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic        m1_lock;
  logic [29:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_be;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_wr;
  logic [31:0] ram_rdata;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata, m0_be,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_be,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_addr, ram_wdata, ram_be, ram_wr,
    input  ram_rdata
  );

  // Requester/RAM side.
  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata, m0_be,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_be,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_addr, ram_wdata, ram_be, ram_wr,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the RAM data port: same-cycle grant, 1-cycle response, no stall beyond gnt=0.
// Fixed-priority (with M1 starvation override) or round-robin, plus owner bus locking for atomics.
module mem_port_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic          gnt0;
  logic          gnt1;
  logic          any_gnt;
  logic          starve;

  logic          owner_q,      owner_d;
  logic          issued_q,     issued_d;
  logic          is_read_q,    is_read_d;
  logic [3:0]    be_q,         be_d;
  logic          rr_ptr_q,     rr_ptr_d;
  logic          lock_q,       lock_d;
  logic          lock_owner_q, lock_owner_d;
  logic [WW-1:0] wait_cnt_q,   wait_cnt_d;

  logic          owner_req;
  logic          gnt_lock;
  logic [31:0]   rd_mask;
  logic [31:0]   resp_dat;

  assign starve  = (MAX_WAIT > 0) && (int'(wait_cnt_q) >= MAX_WAIT);
  assign any_gnt = gnt0 | gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (lock_q) begin
        gnt0 = !lock_owner_q && bus.m0_req;
        gnt1 =  lock_owner_q && bus.m1_req;
      end else if (bus.m0_req && bus.m1_req) begin
        if (ARB_MODE == 1) begin
          gnt0 = !rr_ptr_q;
          gnt1 =  rr_ptr_q;
        end else begin
          gnt0 = !starve;
          gnt1 =  starve;
        end
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;

  // Address and data follow M0 when idle; only the strobe and byte enables are qualified.
  always_comb begin
    bus.ram_addr  = gnt1 ? bus.m1_addr  : bus.m0_addr;
    bus.ram_wdata = gnt1 ? bus.m1_wdata : bus.m0_wdata;
    bus.ram_be    = 4'b0000;
    bus.ram_wr    = 1'b0;
    if (gnt0) begin
      bus.ram_be = bus.m0_be;
      bus.ram_wr = bus.m0_we;
    end else if (gnt1) begin
      bus.ram_be = bus.m1_be;
      bus.ram_wr = bus.m1_we;
    end
  end

  assign owner_req = lock_owner_q ? bus.m1_req : bus.m0_req;
  assign gnt_lock  = gnt1 ? bus.m1_lock : bus.m0_lock;

  always_comb begin
    issued_d     = any_gnt;
    owner_d      = gnt1;
    is_read_d    = gnt1 ? !bus.m1_we : !bus.m0_we;
    be_d         = bus.ram_be;

    rr_ptr_d     = rr_ptr_q;
    if (gnt0) begin
      rr_ptr_d = 1'b1;
    end else if (gnt1) begin
      rr_ptr_d = 1'b0;
    end

    // While locked only the owner can be granted, so a grant without lock ends the sequence.
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (lock_q && !owner_req) begin
      lock_d = 1'b0;
    end
    if (any_gnt) begin
      if (gnt_lock) begin
        lock_d       = 1'b1;
        lock_owner_d = gnt1;
      end else begin
        lock_d       = 1'b0;
      end
    end

    if (bus.m1_req && !gnt1) begin
      wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WW'(1);
    end else begin
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= 1'b0;
      issued_q     <= 1'b0;
      is_read_q    <= 1'b0;
      be_q         <= 4'b0000;
      rr_ptr_q     <= 1'b0;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      owner_q      <= owner_d;
      issued_q     <= issued_d;
      is_read_q    <= is_read_d;
      be_q         <= be_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // The RAM leaves disabled bytes stale, so they are zeroed here.
  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < 4; i++) begin
      rd_mask[8*i +: 8] = {8{be_q[i]}};
    end
  end

  assign resp_dat      = is_read_q ? (bus.ram_rdata & rd_mask) : 32'h0;
  assign bus.m0_rvalid = issued_q && !owner_q;
  assign bus.m1_rvalid = issued_q &&  owner_q;
  assign bus.m0_rdata  = bus.m0_rvalid ? resp_dat : 32'h0;
  assign bus.m1_rdata  = bus.m1_rvalid ? resp_dat : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(gnt0 && gnt1)) else $error("both masters granted in one cycle");
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: a round-robin and a fixed-priority arbiter driven with identical stimulus,
// each with its own RAM, checked against directed constants and a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MODE [2] = '{1, 0};
  localparam int MAXW [2] = '{8, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ram_init;
  logic        m0_req, m0_we, m0_lock;
  logic [29:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_lock;
  logic [29:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_be;

  logic        o_g0 [2], o_g1 [2], o_wr [2], o_rv0 [2], o_rv1 [2];
  logic [3:0]  o_be [2];
  logic [29:0] o_addr [2];
  logic [31:0] o_wd [2], o_rd0 [2], o_rd1 [2];

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h01020305) ^ 32'h5A5AA5A5;
  endfunction

  function automatic logic [31:0] byte_mask(logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_env
    mem_port_arbiter_if bus ();
    logic [31:0] mem [64];
    logic [31:0] rd;

    mem_port_arbiter #(.ARB_MODE(MODE[k]), .MAX_WAIT(MAXW[k])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.m0_req = m0_req;   assign bus.m0_we = m0_we;     assign bus.m0_lock = m0_lock;
    assign bus.m0_addr = m0_addr; assign bus.m0_wdata = m0_wdata; assign bus.m0_be = m0_be;
    assign bus.m1_req = m1_req;   assign bus.m1_we = m1_we;     assign bus.m1_lock = m1_lock;
    assign bus.m1_addr = m1_addr; assign bus.m1_wdata = m1_wdata; assign bus.m1_be = m1_be;
    assign bus.ram_rdata = rd;

    assign o_g0[k] = bus.m0_gnt;      assign o_g1[k] = bus.m1_gnt;
    assign o_wr[k] = bus.ram_wr;      assign o_be[k] = bus.ram_be;
    assign o_addr[k] = bus.ram_addr;  assign o_wd[k] = bus.ram_wdata;
    assign o_rv0[k] = bus.m0_rvalid;  assign o_rv1[k] = bus.m1_rvalid;
    assign o_rd0[k] = bus.m0_rdata;   assign o_rd1[k] = bus.m1_rdata;

    // Synchronous RAM: read data of the addressed word appears one cycle later, whole word.
    always @(posedge clk) begin
      if (ram_init) begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else begin
        rd <= mem[bus.ram_addr[5:0]];
        if (bus.ram_wr)
          for (int b = 0; b < 4; b++)
            if (bus.ram_be[b]) mem[bus.ram_addr[5:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  // Reference model state, one copy per arbiter.
  logic [31:0] smem [2][64];
  int          pref [2], streak [2], lk_who [2], exp_w [2], resp_who [2];
  bit          lk [2];
  logic [31:0] resp_dat [2];
  logic [68:0] exp_g [2], obs_g [2];
  logic [65:0] exp_r [2], obs_r [2];
  logic        sg0 [2], sg1 [2], swr [2], srv0 [2], srv1 [2];
  logic [3:0]  sbe [2];
  logic [31:0] srd0 [2], srd1 [2];

  int checks = 0;
  int passed = 0;

  function automatic int pick(int k);
    if (rst) return -1;
    if (lk[k]) begin
      if (lk_who[k] == 0) return m0_req ? 0 : -1;
      return m1_req ? 1 : -1;
    end
    if (m0_req && m1_req) begin
      if (MODE[k] == 1) return pref[k];
      return (MAXW[k] > 0 && streak[k] >= MAXW[k]) ? 1 : 0;
    end
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  function automatic void model_update(int k);
    int w;
    logic we, lkb, oreq;
    logic [5:0] a;
    logic [3:0] be;
    logic [31:0] wd;
    w = exp_w[k];
    if (rst) begin
      lk[k] = 1'b0; lk_who[k] = 0; pref[k] = 0; streak[k] = 0;
      resp_who[k] = -1; resp_dat[k] = '0;
      return;
    end
    resp_who[k] = w;
    resp_dat[k] = '0;
    oreq = (lk_who[k] == 1) ? m1_req : m0_req;
    if (lk[k] && !oreq) lk[k] = 1'b0;
    if (w >= 0) begin
      we  = (w == 1) ? m1_we   : m0_we;
      lkb = (w == 1) ? m1_lock : m0_lock;
      a   = (w == 1) ? m1_addr[5:0] : m0_addr[5:0];
      be  = (w == 1) ? m1_be   : m0_be;
      wd  = (w == 1) ? m1_wdata : m0_wdata;
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) smem[k][a][8*b +: 8] = wd[8*b +: 8];
      end else begin
        resp_dat[k] = smem[k][a] & byte_mask(be);
      end
      pref[k] = 1 - w;
      if (lkb) begin
        lk[k] = 1'b1; lk_who[k] = w;
      end else if (lk_who[k] == w) begin
        lk[k] = 1'b0;
      end
    end
    if (m1_req && w != 1) streak[k] = (streak[k] < 1000) ? streak[k] + 1 : streak[k];
    else streak[k] = 0;
  endfunction

  // One clock: sample grant-phase outputs mid-cycle, then response outputs just after the edge.
  task automatic tick();
    int w;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      w = pick(k);
      exp_w[k] = w;
      if (w < 0) exp_g[k] = '0;
      else if (w == 0) exp_g[k] = {1'b1, 1'b0, m0_we, m0_be, m0_addr, m0_wdata};
      else exp_g[k] = {1'b0, 1'b1, m1_we, m1_be, m1_addr, m1_wdata};
      sg0[k] = o_g0[k]; sg1[k] = o_g1[k]; swr[k] = o_wr[k]; sbe[k] = o_be[k];
      obs_g[k] = {o_g0[k], o_g1[k], o_wr[k], o_be[k],
                  (o_g0[k] | o_g1[k]) ? o_addr[k] : 30'h0,
                  (o_g0[k] | o_g1[k]) ? o_wd[k] : 32'h0};
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_r[k] = {resp_who[k] == 0, resp_who[k] == 1,
                  (resp_who[k] == 0) ? resp_dat[k] : 32'h0,
                  (resp_who[k] == 1) ? resp_dat[k] : 32'h0};
      srv0[k] = o_rv0[k]; srv1[k] = o_rv1[k]; srd0[k] = o_rd0[k]; srd1[k] = o_rd1[k];
      obs_r[k] = {o_rv0[k], o_rv1[k], o_rd0[k], o_rd1[k]};
    end
  endtask

  task automatic set_idle();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
  endtask

  task automatic drive_m0(logic req, logic we, logic lock, logic [29:0] a, logic [31:0] wd, logic [3:0] be);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = a; m0_wdata = wd; m0_be = be;
  endtask

  task automatic drive_m1(logic req, logic we, logic lock, logic [29:0] a, logic [31:0] wd, logic [3:0] be);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = a; m1_wdata = wd; m1_be = be;
  endtask

  task automatic test_reset();
    rst = 1; ram_init = 1;
    set_idle();
    drive_m0(1, 1, 1, 30'h3, 32'h1111_2222, 4'hF);
    drive_m1(1, 1, 0, 30'h4, 32'h3333_4444, 4'hF);
    for (int c = 0; c < 2; c++) begin
      tick();
      ram_init = 0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({sg0[k], sg1[k], swr[k], sbe[k]} !== 7'b0) $display("FAIL rst_gnt dut%0d: gnt/wr/be got %b want 0", k, {sg0[k], sg1[k], swr[k], sbe[k]});
        else passed++;
      end
    end
    rst = 0;
    set_idle();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({srv0[k], srv1[k], srd0[k], srd1[k]} !== 66'h0) $display("FAIL post_rst_resp dut%0d: got %h want 0", k, {srv0[k], srv1[k], srd0[k], srd1[k]});
      else passed++;
    end
  endtask

  task automatic test_single_read();
    set_idle();
    drive_m0(1, 0, 0, 30'h10, 32'h0, 4'hF);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({sg0[k], sg1[k]} !== 2'b10) $display("FAIL read_gnt dut%0d: got %b want 10", k, {sg0[k], sg1[k]});
      else passed++;
      checks++;
      if ({srv0[k], srv1[k]} !== 2'b10) $display("FAIL read_rvalid dut%0d: got %b want 10", k, {srv0[k], srv1[k]});
      else passed++;
      checks++;
      if (srd0[k] !== 32'hDEADBEEF) $display("FAIL read_data dut%0d: got %h want deadbeef", k, srd0[k]);
      else passed++;
    end
    drive_m0(1, 0, 0, 30'h10, 32'h0, 4'b0010);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (srd0[k] !== 32'h0000BE00) $display("FAIL masked_read dut%0d: got %h want 0000be00", k, srd0[k]);
      else passed++;
    end
    set_idle();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({srv0[k], srv1[k], srd0[k]} !== 34'h0) $display("FAIL idle_resp dut%0d: got %h want 0", k, {srv0[k], srv1[k], srd0[k]});
      else passed++;
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] pat [2];
    pat[0] = 8'b1010_1010;
    pat[1] = 8'b1000_1000;
    rst = 1; set_idle(); tick(); rst = 0;
    drive_m0(1, 0, 0, 30'h1, 32'h0, 4'hF);
    drive_m1(1, 0, 0, 30'h2, 32'h0, 4'hF);
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({sg0[k], sg1[k]} !== {~pat[k][c], pat[k][c]})
          $display("FAIL arb_gnt dut%0d cycle %0d: got %b want %b", k, c, {sg0[k], sg1[k]}, {~pat[k][c], pat[k][c]});
        else passed++;
        checks++;
        if ({srv0[k], srv1[k]} !== {~pat[k][c], pat[k][c]})
          $display("FAIL arb_rvalid dut%0d cycle %0d: got %b want %b", k, c, {srv0[k], srv1[k]}, {~pat[k][c], pat[k][c]});
        else passed++;
      end
    end
  endtask

  task automatic test_lock();
    rst = 1; set_idle(); tick(); rst = 0;
    drive_m0(1, 0, 0, 30'h1, 32'h0, 4'hF);
    drive_m1(1, 0, 0, 30'h2, 32'h0, 4'hF);
    for (int c = 0; c < 3; c++) tick();
    drive_m1(1, 1, 1, 30'h7, 32'hA5A5_5A5A, 4'hF);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({sg0[k], sg1[k], srv1[k], srd1[k]} !== {3'b011, 32'h0})
        $display("FAIL lock_write dut%0d: gnt/rvalid/rdata got %h want %h", k, {sg0[k], sg1[k], srv1[k], srd1[k]}, {3'b011, 32'h0});
      else passed++;
    end
    drive_m1(1, 0, 0, 30'h7, 32'h0, 4'hF);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({sg0[k], sg1[k]} !== 2'b01) $display("FAIL lock_hold dut%0d: got %b want 01", k, {sg0[k], sg1[k]});
      else passed++;
      checks++;
      if (srd1[k] !== 32'hA5A5_5A5A) $display("FAIL lock_readback dut%0d: got %h want a5a55a5a", k, srd1[k]);
      else passed++;
    end
    drive_m1(0, 0, 0, 30'h0, 32'h0, 4'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({sg0[k], sg1[k]} !== 2'b10) $display("FAIL lock_release dut%0d: got %b want 10", k, {sg0[k], sg1[k]});
      else passed++;
    end
  endtask

  task automatic test_reset_mid_op();
    set_idle();
    drive_m0(1, 0, 1, 30'h10, 32'h0, 4'hF);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({sg0[k], srv0[k]} !== 2'b11) $display("FAIL midrst_pre dut%0d: gnt/rvalid got %b want 11", k, {sg0[k], srv0[k]});
      else passed++;
    end
    rst = 1;
    drive_m1(1, 1, 0, 30'h5, 32'h0, 4'hF);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({sg0[k], sg1[k], swr[k], sbe[k], srv0[k], srv1[k]} !== 9'b0)
        $display("FAIL midrst dut%0d: gnt/wr/be/rvalid got %b want 0", k, {sg0[k], sg1[k], swr[k], sbe[k], srv0[k], srv1[k]});
      else passed++;
    end
    rst = 0;
    set_idle();
    drive_m1(1, 0, 0, 30'h10, 32'h0, 4'hF);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({sg0[k], sg1[k], srv0[k]} !== 3'b010) $display("FAIL midrst_unlock dut%0d: got %b want 010", k, {sg0[k], sg1[k], srv0[k]});
      else passed++;
    end
  endtask

  task automatic test_random();
    rst = 1; set_idle(); tick(); rst = 0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive_m0($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 3) == 0,
               30'($urandom), $urandom, 4'($urandom));
      drive_m1($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 3) == 0,
               30'($urandom), $urandom, 4'($urandom));
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_g[k] !== exp_g[k]) $display("FAIL rand_grant dut%0d step %0d: got %h want %h", k, n, obs_g[k], exp_g[k]);
        else passed++;
        checks++;
        if (obs_r[k] !== exp_r[k]) $display("FAIL rand_resp dut%0d step %0d: got %h want %h", k, n, obs_r[k], exp_r[k]);
        else passed++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) smem[k][i] = init_word(i);
      lk[k] = 1'b0; lk_who[k] = 0; pref[k] = 0; streak[k] = 0;
      resp_who[k] = -1; resp_dat[k] = '0; exp_w[k] = -1;
    end
    rst = 1; ram_init = 1;
    set_idle();
    test_reset();
    test_single_read();
    test_arbitration();
    test_lock();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
